// File: rtl/add16_arbiter.sv
// add16_arbiter: two requesters share a single 16-bit adder through a 2:1 operand
// mux. A single-entry output register holds the sum. Round-robin arbitration
// applies when both requesters are valid. Per-requester counters track how many
// results have been delivered.
//
// Ports
//   clk, rst                    clock and synchronous active-high reset
//   reqN_valid/a/b/cin/ready    requester N operand handshake (N = 0, 1)
//   res_valid/sum/cout/id       result register and the requester that produced it
//   res_ready                   consumer accepts the result
//   done_cnt0/done_cnt1         delivered-result counters, wrap at 2^CNT_W
module add16_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [15:0]      res_sum,
  output logic             res_cout,
  output logic             res_id,
  input  logic             res_ready,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [15:0]        sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               id_q, id_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;

  logic        gnt_valid;
  logic        gnt_id;
  logic        can_accept;
  logic        accept;
  logic        drain;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_cin;
  logic [16:0] add_res;

  // Grant: a lone requester wins; on contention the one not granted last time wins.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant_q;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign drain      = (state_q == StFull) && res_ready;
  assign can_accept = !rst && ((state_q == StEmpty) || drain);
  assign accept     = can_accept && gnt_valid;
  assign req0_ready = can_accept && gnt_valid && (gnt_id == 1'b0);
  assign req1_ready = can_accept && gnt_valid && (gnt_id == 1'b1);

  // The one shared adder.
  assign op_a    = gnt_id ? req1_a : req0_a;
  assign op_b    = gnt_id ? req1_b : req0_b;
  assign op_cin  = gnt_id ? req1_cin : req0_cin;
  assign add_res = {1'b0, op_a} + {1'b0, op_b} + {16'd0, op_cin};

  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;

    if (drain) begin
      if (id_q) cnt1_d = cnt1_q + 1'b1;
      else      cnt0_d = cnt0_q + 1'b1;
    end

    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (drain && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase

    if (accept) begin
      sum_d        = add_res[15:0];
      cout_d       = add_res[16];
      id_d         = gnt_id;
      last_grant_d = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StEmpty;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      id_q         <= 1'b0;
      // Starting at 1 makes requester 0 win the first contention.
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign res_valid = (state_q == StFull);
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
  assign res_id    = id_q;
  assign done_cnt0 = cnt0_q;
  assign done_cnt1 = cnt1_q;

endmodule

// File: tb/tb_add16_arbiter.sv
module tb_add16_arbiter;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_cin, req0_ready;
  logic [15:0]   req0_a, req0_b;
  logic          req1_valid, req1_cin, req1_ready;
  logic [15:0]   req1_a, req1_b;
  logic          res_valid, res_cout, res_id, res_ready;
  logic [15:0]   res_sum;
  logic [CW-1:0] done_cnt0, done_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add16_arbiter #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .done_cnt0  (done_cnt0),
    .done_cnt1  (done_cnt1)
  );

  typedef struct {
    logic          rst;
    logic          v0;
    logic [15:0]   a0, b0;
    logic          c0;
    logic          v1;
    logic [15:0]   a1, b1;
    logic          c1;
    logic          rr;
    // expected readys before the edge
    logic          e_r0, e_r1;
    // expected registered outputs after the edge
    logic          e_v;
    logic [15:0]   e_sum;
    logic          e_cout, e_id;
    logic [CW-1:0] e_c0, e_c1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic r, input logic v0, input logic [15:0] a0, input logic [15:0] b0,
    input logic c0, input logic v1, input logic [15:0] a1, input logic [15:0] b1,
    input logic c1, input logic rr, input logic e_r0, input logic e_r1,
    input logic e_v, input logic [15:0] e_sum, input logic e_cout, input logic e_id,
    input logic [CW-1:0] e_c0, input logic [CW-1:0] e_c1);
    vec_t v;
    v.rst = r; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.c0 = c0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.c1 = c1; v.rr = rr;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_v = e_v; v.e_sum = e_sum;
    v.e_cout = e_cout; v.e_id = e_id; v.e_c0 = e_c0; v.e_c1 = e_c1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_cin = v.c0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_cin = v.c1;
    res_ready = v.rr;
  endtask

  task automatic check_regs(input string p, input logic e_v, input logic [15:0] e_sum,
                            input logic e_cout, input logic e_id,
                            input logic [CW-1:0] e_c0, input logic [CW-1:0] e_c1);
    chk({p, " res_valid"}, 32'(res_valid), 32'(e_v));
    chk({p, " res_sum"},   32'(res_sum),   32'(e_sum));
    chk({p, " res_cout"},  32'(res_cout),  32'(e_cout));
    chk({p, " res_id"},    32'(res_id),    32'(e_id));
    chk({p, " done_cnt0"}, 32'(done_cnt0), 32'(e_c0));
    chk({p, " done_cnt1"}, 32'(done_cnt1), 32'(e_c1));
  endtask

  initial begin
    vec_t idle;
    string p;
    idle = mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, '0, '0);

    // Reset held two cycles with both requesters valid: no readys, all outputs 0.
    drive(idle);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      p = $sformatf("reset%0d", i);
      chk({p, " req0_ready"}, 32'(req0_ready), 32'd0);
      chk({p, " req1_ready"}, 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
      check_regs(p, 1'b0, 16'h0, 1'b0, 1'b0, '0, '0);
    end

    //         rst  v0   a0       b0       c0   v1   a1       b1       c1   rr
    //         r0   r1   v    sum      cout id   c0  c1
    vt.push_back(mk(0, 1, 16'h0000, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 1,
                    1, 0, 1, 16'h0010, 0, 0, 8'd0, 8'd0));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1,
                    0, 0, 0, 16'h0010, 0, 0, 8'd1, 8'd0));
    vt.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0,
                    0, 0, 0, 16'h0000, 0, 0, 8'd0, 8'd0));
    // Contention after reset: req0 first, then req1 back-to-back.
    vt.push_back(mk(0, 1, 16'h0010, 16'h0010, 1, 1, 16'hFFFF, 16'h0001, 0, 1,
                    1, 0, 1, 16'h0021, 0, 0, 8'd0, 8'd0));
    vt.push_back(mk(0, 1, 16'h0010, 16'h0010, 1, 1, 16'hFFFF, 16'h0001, 0, 1,
                    0, 1, 1, 16'h0000, 1, 1, 8'd1, 8'd0));
    // Stalled five cycles; operand changes on req0 must not leak in.
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0, 1, 16'(16'h0010 + i), 16'h0010, 1, 1, 16'hFFFF, 16'h0001, 0, 0,
                      0, 0, 1, 16'h0000, 1, 1, 8'd1, 8'd0));
    // Release: drain of req1 result and accept of req0 on the same edge.
    vt.push_back(mk(0, 1, 16'h0010, 16'h0010, 1, 1, 16'hFFFF, 16'h0001, 0, 1,
                    1, 0, 1, 16'h0021, 0, 0, 8'd1, 8'd1));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h1234, 16'h0F0F, 1, 1,
                    0, 1, 1, 16'h2144, 0, 1, 8'd2, 8'd1));
    vt.push_back(mk(0, 1, 16'h8000, 16'h8000, 1, 0, 16'h0000, 16'h0000, 0, 1,
                    1, 0, 1, 16'h0001, 1, 0, 8'd2, 8'd2));
    vt.push_back(mk(0, 1, 16'hFFFF, 16'hFFFF, 1, 0, 16'h0000, 16'h0000, 0, 1,
                    1, 0, 1, 16'hFFFF, 1, 0, 8'd3, 8'd2));
    // Reset with a full register being drained: result dropped, not counted.
    vt.push_back(mk(1, 1, 16'h0001, 16'h0001, 0, 1, 16'h0001, 16'h0001, 0, 1,
                    0, 0, 0, 16'h0000, 0, 0, 8'd0, 8'd0));
    vt.push_back(mk(0, 1, 16'h0001, 16'h0002, 0, 1, 16'h0003, 16'h0004, 0, 1,
                    1, 0, 1, 16'h0003, 0, 0, 8'd0, 8'd0));
    vt.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1,
                    0, 0, 0, 16'h0003, 0, 0, 8'd1, 8'd0));

    foreach (vt[i]) begin
      drive(vt[i]);
      #1;
      p = $sformatf("row%0d", i);
      chk({p, " req0_ready"}, 32'(req0_ready), 32'(vt[i].e_r0));
      chk({p, " req1_ready"}, 32'(req1_ready), 32'(vt[i].e_r1));
      @(posedge clk); #1;
      check_regs(p, vt[i].e_v, vt[i].e_sum, vt[i].e_cout, vt[i].e_id,
                 vt[i].e_c0, vt[i].e_c1);
    end

    // 256 back-to-back req0 completions wrap done_cnt0 to 0.
    drive(idle);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; res_ready = 1'b1;
    begin
      int not_ready = 0;
      for (int i = 0; i < 256; i++) begin
        #1;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) not_ready++;
        @(posedge clk); #1;
        if (i == 255) chk("wrap cnt0 at 255", 32'(done_cnt0), 32'd255);
      end
      chk("wrap ready every cycle", 32'(not_ready), 32'd0);
    end
    req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("wrap res_valid", 32'(res_valid), 32'd0);
    chk("wrap cnt0", 32'(done_cnt0), 32'd0);
    chk("wrap cnt1", 32'(done_cnt1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add16_arbiter.md
ADD16_ARBITER -- requirements
Module: add16_arbiter

Interface
REQ-001 Parameter: CNT_W, default 8, width of the per-requester completion counters.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 holds an operand set.
REQ-005 req0_a / req0_b  input  16 each  requester 0 operands, unsigned.
REQ-006 req0_cin  input  1  requester 0 carry-in.
REQ-007 req0_ready  output  1  requester 0 operands accepted this cycle when high with req0_valid.
REQ-008 req1_valid, req1_a, req1_b, req1_cin, req1_ready  same directions, widths and meanings as REQ-004..REQ-007, for requester 1.
REQ-009 res_valid  output  1  result register holds an undelivered result.
REQ-010 res_sum  output  16  low 16 bits of a+b+cin.
REQ-011 res_cout  output  1  carry-out, bit 16 of a+b+cin.
REQ-012 res_id  output  1  requester that produced the result (0 or 1).
REQ-013 res_ready  input  1  consumer accepts the result when high with res_valid.
REQ-014 done_cnt0 / done_cnt1  output  CNT_W each  delivered results per requester.

Function
REQ-015 The block SHALL contain exactly one 16-bit adder, shared between both requesters through a 2:1 operand mux.
REQ-016 Output-register states SHALL be EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-017 can_accept SHALL equal (state==EMPTY) or (res_valid and res_ready), and SHALL be 0 while rst=1.
REQ-018 Grant: one requester valid -> that requester; both valid -> the requester not named by last_grant; none -> no grant.
REQ-019 reqN_ready SHALL equal can_accept and (grant==N); at most one ready SHALL be high per cycle.
REQ-020 Accept (ready and valid) SHALL load res_sum, res_cout, res_id from the granted operands on the same edge, so res_valid rises the cycle after acceptance (latency 1).
REQ-021 last_grant SHALL update to the accepted requester only on an accept.
REQ-022 Transitions: EMPTY+accept -> FULL; FULL+drain, no accept -> EMPTY; FULL+drain+accept -> FULL with new result (back-to-back, one result per cycle); FULL, no drain -> FULL, all outputs stable.
REQ-023 Arithmetic SHALL be {res_cout,res_sum} = a + b + cin in 17 bits, no saturation.
REQ-024 On drain (res_valid and res_ready), done_cnt[res_id] SHALL increment by 1, wrapping from 2^CNT_W-1 to 0.
REQ-025 Operand inputs of a non-granted or non-accepted requester SHALL have no effect on state.

Reset
REQ-026 While rst=1 at an edge: state=EMPTY, res_valid=0, res_sum=0, res_cout=0, res_id=0, last_grant=1, done_cnt0=0, done_cnt1=0.
REQ-027 Reset SHALL take priority over accept and drain in the same cycle; a held result SHALL be discarded and not counted.
REQ-028 After reset, requester 0 SHALL win the first contention.

Verification
REQ-029 rst=1 two cycles -> all outputs 0, req0_ready=req1_ready=0 during reset.
REQ-030 Only req0: a=0, b=16, cin=0, res_ready=1 -> next cycle res_valid=1, res_sum=16, res_cout=0, res_id=0; done_cnt0=1 after drain.
REQ-031 Both valid after reset: req0 a=16, b=16, cin=1; req1 a=0xFFFF, b=1, cin=0; res_ready=1 -> first result sum=33, cout=0, id=0; next cycle sum=0, cout=1, id=1.
REQ-032 res_ready=0 with FULL and both valid -> both readys 0 and result stable for 5 cycles; res_ready=1 -> drain plus new accept on the same edge.
REQ-033 256 back-to-back req0 completions with CNT_W=8 -> done_cnt0 wraps to 0, done_cnt1 stays 0.
REQ-034 rst=1 while res_valid=1 and res_ready=1 -> next cycle res_valid=0, done counters 0, req0 wins the next contention.
